// File: rtl/cnn_pkg.sv
// Shared constants, FSM state type and per-class bias table for the
// CNN classifier back end.
// Scores are signed two's complement Q8.8 (CNN_FRAC_BITS fractional bits).
// BIAS_TABLE is only used when ARGMAX_BIAS_EN is defined.
package cnn_pkg;

    localparam int unsigned CNN_DW        = 16;
    localparam int unsigned CNN_N_CLASS   = 10;
    localparam int unsigned CNN_FRAC_BITS = 8;
    localparam int unsigned ID_W          = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Per-class bias in Q8.8, index 0 first.
    localparam logic [CNN_DW-1:0] BIAS_TABLE [CNN_N_CLASS] = '{
        16'h0200, 16'hFF80, 16'h0040, 16'h0000, 16'h0100,
        16'hFE00, 16'h0080, 16'h0000, 16'hFFC0, 16'h0010
    };

endpackage

// File: rtl/argmax_classifier_if.sv
// Handshake bundle between the fully-connected stage and the argmax classifier.
//   i_fl_done   : FC completion flag (level, may stay high)
//   i_score     : packed class scores, element i = class i
//   o_busy      : capture-to-result window
//   o_valid     : one-cycle result strobe
//   o_class_id  : winning class index
//   o_max_score : winning score
//   o_overrun   : one-cycle pulse when a completion rise is dropped
interface argmax_classifier_if #(
    parameter int unsigned N_CLASS = cnn_pkg::CNN_N_CLASS,
    parameter int unsigned DW      = cnn_pkg::CNN_DW
);

    logic                         i_fl_done;
    logic [N_CLASS-1:0][DW-1:0]   i_score;
    logic                         o_busy;
    logic                         o_valid;
    logic [cnn_pkg::ID_W-1:0]     o_class_id;
    logic [DW-1:0]                o_max_score;
    logic                         o_overrun;

    modport master (
        output i_fl_done, i_score,
        input  o_busy, o_valid, o_class_id, o_max_score, o_overrun
    );

    modport slave (
        input  i_fl_done, i_score,
        output o_busy, o_valid, o_class_id, o_max_score, o_overrun
    );

endinterface

// File: rtl/sat_add.sv
// DW-bit signed saturating adder used to apply per-class bias.
// Only compiled when ARGMAX_BIAS_EN is defined.
//   i_a, i_b : signed operands
//   o_sum_c  : combinational sum clamped to the DW-bit signed range
`ifdef ARGMAX_BIAS_EN
module sat_add #(
    parameter int unsigned DW = 16
) (
    input  logic signed [DW-1:0] i_a,
    input  logic signed [DW-1:0] i_b,
    output logic signed [DW-1:0] o_sum_c
);

    localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

    logic [DW:0] w_sum;

    // One guard bit; overflow when the two top bits disagree.
    always_comb begin
        w_sum   = {i_a[DW-1], i_a} + {i_b[DW-1], i_b};
        o_sum_c = w_sum[DW-1:0];
        if (w_sum[DW] != w_sum[DW-1]) begin
            o_sum_c = w_sum[DW] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule
`endif

// File: rtl/argmax_classifier.sv
// Argmax over N_CLASS signed scores, one score per clock.
// On a rising edge of i_fl_done in IDLE the scores are captured; the scan then
// walks the captured copy and issues class_id/max_score with a one-cycle valid
// exactly N_CLASS clocks after the capture edge. Ties keep the lower index.
// Ports: clk, rst (async, active-high), bus (argmax_classifier_if.slave).
// Build option: ARGMAX_BIAS_EN adds a saturating per-class bias before compare.
module argmax_classifier
    import cnn_pkg::*;
#(
    parameter int unsigned N_CLASS = CNN_N_CLASS,
    parameter int unsigned DW      = CNN_DW
) (
    input  logic                 clk,
    input  logic                 rst,
    argmax_classifier_if.slave   bus
);

    localparam int unsigned          IDX_W    = ID_W;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N_CLASS - 1);
    localparam logic signed [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};

    state_t                  r_state;
    logic                    r_fl_prev;
    logic [DW-1:0]           r_score [N_CLASS];
    logic [IDX_W-1:0]        r_index;
    logic [IDX_W-1:0]        r_best_id;
    logic signed [DW-1:0]    r_best;
    logic                    r_busy;
    logic                    r_valid;
    logic                    r_overrun;
    logic [IDX_W-1:0]        r_class_id;
    logic [DW-1:0]           r_max_score;

    logic                    w_rise;
    logic signed [DW-1:0]    w_raw;
    logic signed [DW-1:0]    w_cand;
    logic                    w_gt;

    assign w_rise = bus.i_fl_done & ~r_fl_prev;
    assign w_raw  = r_score[r_index];

`ifdef ARGMAX_BIAS_EN
    sat_add #(.DW(DW)) u_sat_add (
        .i_a     (w_raw),
        .i_b     (BIAS_TABLE[r_index]),
        .o_sum_c (w_cand)
    );
`else
    assign w_cand = w_raw;
`endif

    // Strict greater-than so an equal later score never displaces the leader.
    assign w_gt = w_cand > r_best;

    // Score snapshot; only taken from IDLE so a dropped rise cannot disturb it.
    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && w_rise) begin
            for (int unsigned i = 0; i < N_CLASS; i++) begin
                r_score[i] <= bus.i_score[i];
            end
        end
    end

    // Control FSM and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_fl_prev   <= 1'b0;
            r_index     <= '0;
            r_best_id   <= '0;
            r_best      <= MOST_NEG;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_class_id  <= '0;
            r_max_score <= '0;
        end else begin
            r_fl_prev <= bus.i_fl_done;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_state   <= ST_SCAN;
                        r_index   <= '0;
                        r_best    <= MOST_NEG;
                        r_best_id <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    r_overrun <= w_rise;
                    if (w_gt) begin
                        r_best    <= w_cand;
                        r_best_id <= r_index;
                    end
                    r_index <= r_index + IDX_W'(1);
                    // Last element folds straight into the result registers.
                    if (r_index == LAST_IDX) begin
                        r_state     <= ST_DONE;
                        r_valid     <= 1'b1;
                        r_class_id  <= w_gt ? r_index : r_best_id;
                        r_max_score <= w_gt ? w_cand : r_best;
                    end
                end
                ST_DONE: begin
                    r_overrun <= w_rise;
                    r_state   <= ST_IDLE;
                    r_busy    <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_busy      = r_busy;
    assign bus.o_valid     = r_valid;
    assign bus.o_overrun   = r_overrun;
    assign bus.o_class_id  = r_class_id;
    assign bus.o_max_score = r_max_score;

endmodule

// File: tb/tb_argmax_classifier.sv
// Self-checking bench for argmax_classifier: expected results are computed by a
// reference argmax when a capture is launched, queued, and compared (id, score,
// arrival cycle) whenever the DUT strobes valid.
module tb_argmax_classifier;
    import cnn_pkg::*;

    localparam int unsigned NC = CNN_N_CLASS;
    localparam int unsigned DW = CNN_DW;

    typedef struct {
        logic [3:0]    id;
        logic [DW-1:0] score;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    argmax_classifier_if #(.N_CLASS(NC), .DW(DW)) bus ();

    argmax_classifier #(.N_CLASS(NC), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t          q[$];
    exp_t          e_pop;
    logic [DW-1:0] sc [NC];
    int            cyc      = 0;
    int            n_checks = 0;
    int            n_pass   = 0;
    int            n_valid  = 0;
    int            n_ovr    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference argmax over sc[], with saturating bias when compiled in.
    function automatic exp_t model_result();
        exp_t r;
        int   best;
        int   t;
        best    = -32768;
        r.id    = 4'd0;
        r.score = 16'h8000;
        r.cyc   = 0;
        for (int i = 0; i < NC; i++) begin
            t = int'($signed(sc[i]));
`ifdef ARGMAX_BIAS_EN
            t = t + int'($signed(BIAS_TABLE[i]));
            if (t > 32767)  t = 32767;
            if (t < -32768) t = -32768;
`endif
            if (t > best) begin
                best    = t;
                r.id    = 4'(i);
                r.score = 16'(t);
            end
        end
        return r;
    endfunction

    // Output monitor: sample 1 time unit after each rising edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (bus.o_overrun === 1'b1) n_ovr++;
        if (bus.o_valid === 1'b1) begin
            n_valid++;
            if (q.size() == 0) begin
                check("spurious_valid", 32'd1, 32'd0);
            end else begin
                e_pop = q.pop_front();
                check("class_id",  32'(bus.o_class_id),  32'(e_pop.id));
                check("max_score", 32'(bus.o_max_score), 32'(e_pop.score));
                check("latency",   32'(cyc),             32'(e_pop.cyc));
            end
        end
    end

    task automatic apply_scores();
        for (int i = 0; i < NC; i++) bus.i_score[i] = sc[i];
    endtask

    // Called just after a falling edge: the next rising edge detects the rise.
    task automatic launch();
        exp_t e;
        apply_scores();
        bus.i_fl_done = 1'b1;
        e     = model_result();
        e.cyc = cyc + 1 + NC;
        q.push_back(e);
    endtask

    task automatic scramble();
        for (int i = 0; i < NC; i++) bus.i_score[i] = DW'($urandom);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        check({tag, "_drain"}, 32'(q.size()), 32'd0);
        bus.i_fl_done = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Single capture with inputs disturbed during the scan.
    task automatic run_case(input string tag);
        @(negedge clk);
        launch();
        @(negedge clk);
        check({tag, "_busy"}, 32'(bus.o_busy), 32'd1);
        bus.i_fl_done = 1'b0;
        scramble();
        drain(tag);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"},      32'(bus.o_busy),      32'd0);
        check({tag, "_valid"},     32'(bus.o_valid),     32'd0);
        check({tag, "_overrun"},   32'(bus.o_overrun),   32'd0);
        check({tag, "_class_id"},  32'(bus.o_class_id),  32'd0);
        check({tag, "_max_score"}, 32'(bus.o_max_score), 32'd0);
    endtask

    int v0;
    int o0;

    initial begin
        rst           = 1'b1;
        bus.i_fl_done = 1'b0;
        for (int i = 0; i < NC; i++) sc[i] = '0;
        apply_scores();
        #1;
        check_idle_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic: peak at class 1.
        for (int i = 0; i < NC; i++) sc[i] = 16'h0000;
        sc[0] = 16'h0100; sc[1] = 16'h0300; sc[2] = 16'h0200;
        run_case("basic");

        // All negative, peak at the last index.
        for (int i = 0; i < 9; i++) sc[i] = 16'hF000 + 16'(i * 16);
        sc[9] = 16'hFF80;
        run_case("negative");

        // Tie between classes 3 and 7.
        for (int i = 0; i < NC; i++) sc[i] = 16'hFC00;
        sc[3] = 16'h0500; sc[7] = 16'h0500;
        run_case("tie");

        // All equal.
        for (int i = 0; i < NC; i++) sc[i] = 16'h0123;
        run_case("equal");

        // All at the most negative value.
        for (int i = 0; i < NC; i++) sc[i] = 16'h8000;
        run_case("all_min");

        // Maximum positive at the last index.
        for (int i = 0; i < NC; i++) sc[i] = 16'h8000;
        sc[9] = 16'h7FFF;
        run_case("max_last");

        // Near-full-scale score at class 0 (saturates when bias is compiled in).
        for (int i = 0; i < NC; i++) sc[i] = 16'h0000;
        sc[0] = 16'h7F00;
        run_case("sat");

        // Random vectors.
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NC; i++) sc[i] = DW'($urandom);
            run_case("rand");
        end

        // Level held high for 40 cycles: one result, no overrun.
        for (int i = 0; i < NC; i++) sc[i] = 16'(i * 32);
        v0 = n_valid;
        o0 = n_ovr;
        @(negedge clk);
        launch();
        repeat (40) @(negedge clk);
        check("hold_valid_count", 32'(n_valid - v0), 32'd1);
        check("hold_overrun",     32'(n_ovr - o0),   32'd0);
        drain("hold");

        // Second rise during the scan: dropped with a single overrun pulse.
        for (int i = 0; i < NC; i++) sc[i] = 16'h0010;
        sc[4] = 16'h0400;
        o0 = n_ovr;
        @(negedge clk);
        launch();
        @(negedge clk);
        bus.i_fl_done = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < NC; i++) bus.i_score[i] = 16'h0010;
        bus.i_score[8] = 16'h7000;
        bus.i_fl_done = 1'b1;
        @(negedge clk);
        bus.i_fl_done = 1'b0;
        drain("overrun");
        check("overrun_pulses", 32'(n_ovr - o0), 32'd1);

        // Reset mid-scan with the flag still high at release.
        for (int i = 0; i < NC; i++) sc[i] = 16'h0000;
        sc[6] = 16'h0250;
        @(negedge clk);
        launch();
        repeat (4) @(negedge clk);
        rst = 1'b1;
        q.delete();
        #1;
        check_idle_zero("mid_reset");
        v0 = n_valid;
        repeat (3) @(negedge clk);
        check("reset_no_valid", 32'(n_valid - v0), 32'd0);
        for (int i = 0; i < NC; i++) sc[i] = 16'h0000;
        sc[2] = 16'h0333;
        rst = 1'b0;
        launch();
        @(negedge clk);
        bus.i_fl_done = 1'b0;
        scramble();
        drain("post_reset");

        check("final_queue", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/argmax_classifier.md
ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

Interface
REQ-001 SHALL have parameter N_CLASS, default 10, number of class scores.
REQ-002 SHALL have parameter DW, default 16, score width (signed two's complement, Q8.8).
REQ-003 clk  input  1  clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 fl_done  input  1  completion flag from the fully-connected stage; may stay high many cycles.
REQ-006 score0..score9  input  DW each  fully-connected outputs, stable while fl_done high.
REQ-007 busy  output  1  high from capture until result issued.
REQ-008 valid  output  1  one-cycle result strobe.
REQ-009 class_id  output  4  index of winning class.
REQ-010 max_score  output  DW  winning score (post-bias when bias compiled in).
REQ-011 overrun  output  1  one-cycle pulse when a new fl_done rise is dropped.

Function
REQ-012 SHALL register fl_done and detect its rising edge (fl_done=1, previous=0); level-high alone SHALL NOT retrigger.
REQ-013 FSM states: IDLE, SCAN, DONE; IDLE->SCAN on detected rise; SCAN->DONE after index N_CLASS-1 processed; DONE->IDLE unconditionally next cycle.
REQ-014 At the detecting edge (k) SHALL capture all scores into an internal array, set index=0, best=most-negative DW value, best_id=0, busy=1.
REQ-015 SCAN SHALL process one score per clock, edges k+1..k+N_CLASS, index incrementing by 1.
REQ-016 Comparison SHALL be signed, strictly greater-than; ties SHALL keep the lower index.
REQ-017 At edge k+N_CLASS SHALL load class_id, max_score from best and set valid=1; valid SHALL clear at the next edge along with busy.
REQ-018 Latency: valid high exactly N_CLASS clocks after the detecting edge (10 by default).
REQ-019 class_id, max_score SHALL hold until the next result, unchanged outside the DONE-entry edge.
REQ-020 Rising edge of fl_done while busy SHALL be ignored and SHALL pulse overrun for one cycle; captured array SHALL not change.
REQ-021 Input changes during SCAN SHALL NOT affect the result.
REQ-022 All-equal scores SHALL yield class_id=0.

Reset
REQ-023 rst SHALL force IDLE, busy=0, valid=0, overrun=0, class_id=0, max_score=0, edge register=0, index=0, immediately.
REQ-024 Reset during SCAN SHALL abandon the scan with no valid pulse; fl_done already high at release SHALL trigger a capture at the first clock after release (edge register reset to 0).

Configuration
REQ-025 Macro ARGMAX_BIAS_EN defined: each score SHALL have a per-class DW-bit bias constant added with signed saturation to [-32768, 32767] before comparison; max_score reports the biased value.
REQ-026 ARGMAX_BIAS_EN undefined: raw scores compared, no adder logic instantiated.

Structure
REQ-027 Shared package cnn_pkg SHALL hold DW, N_CLASS, Q-format fraction bits, FSM state typedef, and the bias constant table.
REQ-028 One sub-module sat_add (DW-bit signed saturating adder) SHALL be instantiated only under ARGMAX_BIAS_EN.

Verification
REQ-029 Scores {0x0100,0x0300,0x0200,...,0x0000} with single fl_done rise -> valid 10 clocks later, class_id=1, max_score=0x0300.
REQ-030 All scores negative, max at index 9 = 0xFF80 (others below) -> class_id=9, max_score=0xFF80; checks signed compare.
REQ-031 score3=score7=0x0500 maximal -> class_id=3.
REQ-032 fl_done held high 40 cycles -> exactly one valid pulse; second rise at cycle 5 of scan -> overrun pulse, result unchanged.
REQ-033 rst asserted at scan cycle 4 -> no valid, all outputs 0; fl_done high at release -> full result 10 clocks after first post-release edge.
REQ-034 With ARGMAX_BIAS_EN, score 0x7F00 plus bias 0x0200 -> max_score=0x7FFF (saturated).
